async_fifo_rd_stream: RTL

//  Read-side drain for the async FIFO. Pops words from the FIFO read port (rdata/rempty/rinc)
//  and presents them as a valid/ready flit stream for the NoC router input port.

---
 rtl/async_fifo_rd_stream_pkg.sv | 13 +
 rtl/async_fifo_rd_stream_if.sv | 27 ++
 rtl/async_fifo_rd_stream_skid_buf2.sv | 63 ++++++
 rtl/async_fifo_rd_stream.sv | 127 ++++++++++++
 4 files changed

// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared definitions for the async FIFO read-side drain: framing FSM states
// and default header-field placement.
package async_fifo_rd_stream_pkg;

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } frame_state_e;

    localparam int LEN_LSB_DEF = 0;
    localparam int LEN_W_DEF   = 8;

endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// Flit stream toward the NoC router input port: valid/ready handshake plus
// packet framing tags.
interface async_fifo_rd_stream_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/async_fifo_rd_stream_skid_buf2.sv
// Generic 2-entry in-order valid/ready buffer. Outputs come straight from
// registers, so out_ready never reaches the enqueue side combinationally.
module fifo_skid_buf2 #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] slot0_r;
    logic [W-1:0] slot1_r;
    logic [1:0]   count_r;
    logic         enq_s;
    logic         deq_s;

    assign out_valid = (count_r != 2'd0);
    assign out_data  = slot0_r;
    assign count     = count_r;
    assign enq_s     = in_valid && (count_r != 2'd2);
    assign deq_s     = (count_r != 2'd0) && out_ready;

    // Entry storage and occupancy; slot0 is always the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            slot0_r <= {W{1'b0}};
            slot1_r <= {W{1'b0}};
        end else begin
            case (count_r)
                2'd0: begin
                    if (enq_s) begin
                        slot0_r <= in_data;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (enq_s && deq_s) begin
                        slot0_r <= in_data;
                    end else if (enq_s) begin
                        slot1_r <= in_data;
                        count_r <= 2'd2;
                    end else if (deq_s) begin
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (deq_s) begin
                        slot0_r <= slot1_r;
                        count_r <= 2'd1;
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side drain: pops FIFO words, frames them into sop/eop-tagged flits
// from the header length field and streams them out through a 2-entry buffer.
module async_fifo_rd_stream
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_LSB = LEN_LSB_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DATA_W-1:0]      rdata,
    input  logic                   rempty,
    output logic                   rinc,
    async_fifo_rd_stream_if.master flit,
    output logic [CNT_W-1:0]       flit_cnt
);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    frame_state_e      state_r;
    frame_state_e      state_nxt_s;
    logic [LEN_W-1:0]  remaining_r;
    logic [LEN_W-1:0]  remaining_nxt_s;
    logic [LEN_W-1:0]  len_s;
    logic              sop_s;
    logic              eop_s;
    logic              pop_s;
    logic [1:0]        count_s;
    logic [DATA_W+1:0] buf_din_s;
    logic [DATA_W+1:0] buf_dout_s;
    logic              buf_valid_s;
    logic              fire_s;
    logic [CNT_W-1:0]  flit_cnt_r;

    // Pop depends only on FIFO state and buffer room, never on out_ready.
    assign pop_s     = !rrst && !rempty && (count_s != 2'd2);
    assign rinc      = pop_s;
    assign len_s     = rdata[LEN_LSB +: LEN_W];
    assign buf_din_s = {sop_s, eop_s, rdata};
    assign fire_s    = buf_valid_s && flit.out_ready;

    assign flit.out_valid = buf_valid_s;
    assign flit.out_data  = buf_dout_s[DATA_W-1:0];
    assign flit.out_eop   = buf_dout_s[DATA_W];
    assign flit.out_sop   = buf_dout_s[DATA_W+1];
    assign flit_cnt       = flit_cnt_r;

    // Framing tags for the word on rdata and next framing state on a pop.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        sop_s           = 1'b0;
        eop_s           = 1'b0;
        case (state_r)
            ST_HEAD: begin
                sop_s = 1'b1;
                if (len_s == LEN_ZERO) begin
                    eop_s = 1'b1;
                end else begin
                    eop_s = 1'b0;
                    if (pop_s) begin
                        remaining_nxt_s = len_s;
                        state_nxt_s     = ST_BODY;
                    end else begin
                        remaining_nxt_s = remaining_r;
                        state_nxt_s     = ST_HEAD;
                    end
                end
            end
            ST_BODY: begin
                sop_s = 1'b0;
                eop_s = (remaining_r == LEN_ONE);
                if (pop_s) begin
                    remaining_nxt_s = remaining_r - LEN_ONE;
                    if (remaining_r == LEN_ONE) begin
                        state_nxt_s = ST_HEAD;
                    end else begin
                        state_nxt_s = ST_BODY;
                    end
                end else begin
                    remaining_nxt_s = remaining_r;
                    state_nxt_s     = ST_BODY;
                end
            end
            default: begin
                state_nxt_s     = ST_HEAD;
                remaining_nxt_s = LEN_ZERO;
            end
        endcase
    end

    // Framing state register; reset drops any partial packet.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r     <= ST_HEAD;
            remaining_r <= LEN_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    // Delivered-flit counter, wrapping naturally at its width.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            flit_cnt_r <= {CNT_W{1'b0}};
        end else if (fire_s) begin
            flit_cnt_r <= flit_cnt_r + CNT_ONE;
        end
    end

    fifo_skid_buf2 #(
        .W (DATA_W + 2)
    ) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .in_valid  (pop_s),
        .in_data   (buf_din_s),
        .out_valid (buf_valid_s),
        .out_ready (flit.out_ready),
        .out_data  (buf_dout_s),
        .count     (count_s)
    );
endmodule
